// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK_RATIO of them into one valid/ready beat; an idle partial beat is flushed with a keep mask.
// Latency: a beat is presented the cycle after its last word is captured. Reads stop when the returning word would have no free lane.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_fifo_empty,
    output logic                             o_fifo_rden,
    input  logic [DATA_WIDTH-1:0]            i_fifo_rdata,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] o_tdata,
    output logic [PACK_RATIO-1:0]            o_tkeep,
    output logic                             o_tvalid,
    input  logic                             i_tready
);

    localparam int LW = $clog2(PACK_RATIO) + 1;
    localparam int IW = $clog2(PACK_RATIO);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] LANES_FULL = LW'(PACK_RATIO);
    localparam logic [LW-1:0] LANES_LAST = LW'(PACK_RATIO - 1);
    localparam logic [TW-1:0] TO_LAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]                           r_state;
    logic [1:0]                           w_state_nxt;
    logic [LW-1:0]                        r_lane_cnt;
    logic [LW-1:0]                        w_lane_nxt;
    logic                                 r_inflight;
    logic [TW-1:0]                        r_tcnt;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] r_acc;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] w_beat;
    logic [DATA_WIDTH*PACK_RATIO-1:0]     r_tdata;
    logic [PACK_RATIO-1:0]                r_tkeep;
    logic [PACK_RATIO-1:0]                w_keep;
    logic                                 r_tvalid;
    logic [LW-1:0]                        w_beat_cnt;
    logic [IW-1:0]                        w_lane_idx;
    logic                                 w_cap;
    logic                                 w_cap_lane;
    logic                                 w_complete;
    logic                                 w_flush;
    logic                                 w_out_free;
    logic                                 w_xfer;
    logic                                 w_room;

    assign w_cap      = r_inflight;
    // In FULL the accumulator is spoken for, so a capture belongs to the next beat.
    assign w_cap_lane = r_inflight && (r_state != S_FULL);
    assign w_lane_idx = r_lane_cnt[IW-1:0];

    // The last word may complete the beat and leave in the same cycle it is captured.
    assign w_complete = (r_state == S_FULL) || (w_cap && (r_lane_cnt == LANES_LAST));
    assign w_flush    = (TIMEOUT > 0) && (r_state == S_FILL) && !r_inflight
                        && (r_tcnt == TO_LAST);
    assign w_out_free = !r_tvalid || i_tready;
    assign w_xfer     = w_out_free && (w_complete || w_flush);

    // A read is safe if its word has a lane now, or the beat leaves this cycle and lane 0 opens.
    assign w_room      = ({1'b0, r_lane_cnt} + {{LW{1'b0}}, r_inflight})
                         < (LW + 1)'(PACK_RATIO);
    assign o_fifo_rden = !i_rst && !i_fifo_empty && (w_xfer || w_room);

    always_comb begin
        w_beat = r_acc;
        if (w_cap_lane) begin
            w_beat[w_lane_idx] = i_fifo_rdata;
        end
        w_beat_cnt = r_lane_cnt + LW'(w_cap_lane);
        for (int i = 0; i < PACK_RATIO; i++) begin
            w_keep[i] = (LW'(i) < w_beat_cnt);
        end
    end

    always_comb begin
        if (w_xfer) begin
            w_lane_nxt = (w_cap && !w_cap_lane) ? LW'(1) : '0;
        end else begin
            w_lane_nxt = r_lane_cnt + LW'(w_cap);
        end

        if (w_lane_nxt == '0) begin
            w_state_nxt = S_IDLE;
        end else if (w_lane_nxt == LANES_FULL) begin
            w_state_nxt = S_FULL;
        end else begin
            w_state_nxt = S_FILL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lane_cnt <= '0;
            r_inflight <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_nxt;
            r_inflight <= o_fifo_rden;
            if (w_xfer) begin
                r_acc <= '0;
                if (w_cap && !w_cap_lane) begin
                    r_acc[0] <= i_fifo_rdata;
                end
            end else if (w_cap) begin
                r_acc[w_lane_idx] <= i_fifo_rdata;
            end
        end
    end

    // Holds at its last value while a flush waits on a stalled output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tcnt <= '0;
        end else if (w_cap || o_fifo_rden || w_xfer || r_inflight || (r_state != S_FILL)) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TO_LAST) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
        end else if (w_xfer) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_beat;
            r_tkeep  <= w_keep;
        end else if (i_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tvalid = r_tvalid;

endmodule
